// File: rtl/itree_pattern_tx_if.sv
// Valid/ready byte stream from itree_pattern_tx to the isolation-tree matcher.
// The transmitter drives through the master modport and the matcher listens on the slave modport.
interface itree_pattern_tx_if #(
  parameter int BYTE_W = 8
);
  logic [BYTE_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_out, data_valid, input data_ready);
  modport slave  (input data_out, data_valid, output data_ready);
endinterface

// File: rtl/itree_pattern_tx.sv
// Serialises a latched reference pattern LSB-first into byte beats, with frame repeats, an idle gap and abort.
// Optional first-frame single-bit corruption is enabled by defining ITREE_TX_FAULT_INJECT_EN.
module itree_pattern_tx #(
  parameter int PATTERN_W  = 256,
  parameter int BYTE_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic [7:0]           repeat_count,
`ifdef ITREE_TX_FAULT_INJECT_EN
  input  logic                 inject_en,
  input  logic [7:0]           inject_idx,
`endif
  itree_pattern_tx_if.master   tx,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           byte_index
);

  localparam int BEATS  = PATTERN_W / BYTE_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FINISH} state_t;

  state_t               state, state_next;
  logic [PATTERN_W-1:0] pattern;
  logic [PATTERN_W-1:0] tx_pattern;
  logic [BEAT_W-1:0]    beat;
  logic [7:0]           frames_left;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 accept_start;
  logic                 xfer;
  logic                 last_xfer;

  assign accept_start = (state == IDLE) && start && !abort;
  assign xfer         = tx.data_valid && tx.data_ready;
  assign last_xfer    = (state == SEND) && xfer && (beat == BEAT_LAST);

`ifdef ITREE_TX_FAULT_INJECT_EN
  logic       inj_en_q;
  logic [7:0] inj_idx_q;
  logic       first_frame;

  // A shift past the top bit leaves the mask empty, so out-of-range indices flip nothing.
  assign tx_pattern = (inj_en_q && first_frame)
                    ? pattern ^ (PATTERN_W'(1) << inj_idx_q)
                    : pattern;
`else
  assign tx_pattern = pattern;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_start) state_next = SEND;
      SEND:    if (last_xfer) begin
                 if (frames_left > 8'd1) state_next = (GAP_CYCLES == 0) ? SEND : GAP;
                 else                    state_next = FINISH;
               end
      GAP:     if (gap_cnt == GAP_LAST) state_next = SEND;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      // NOTE: the wide pattern register is a plain flop bank, so clearing it on reset is cheap and deterministic.
      pattern     <= '0;
      beat        <= '0;
      frames_left <= '0;
      gap_cnt     <= '0;
`ifdef ITREE_TX_FAULT_INJECT_EN
      inj_en_q    <= 1'b0;
      inj_idx_q   <= '0;
      first_frame <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (accept_start) begin
        pattern     <= pattern_in;
        frames_left <= (repeat_count == 8'd0) ? 8'd1 : repeat_count;
        beat        <= '0;
        gap_cnt     <= '0;
`ifdef ITREE_TX_FAULT_INJECT_EN
        inj_en_q    <= inject_en;
        inj_idx_q   <= inject_idx;
        first_frame <= 1'b1;
`endif
      end else if (state == SEND && xfer) begin
        if (beat == BEAT_LAST) begin
          beat    <= '0;
          gap_cnt <= '0;
          if (frames_left != 8'd0) frames_left <= frames_left - 8'd1;
`ifdef ITREE_TX_FAULT_INJECT_EN
          first_frame <= 1'b0;
`endif
        end else begin
          beat <= beat + 1'b1;
        end
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  // Outputs are decoded from state so the abort cycle still presents its beat.
  assign tx.data_valid = (state == SEND);
  assign tx.data_out   = (state == SEND) ? tx_pattern[int'(beat)*BYTE_W +: BYTE_W] : '0;
  assign byte_index    = (state == SEND) ? 8'(beat) : 8'd0;
  assign busy          = (state == SEND) || (state == GAP);
  assign done          = (state == FINISH) && !abort;

endmodule

// File: tb/tb_itree_pattern_tx.sv
// Directed bench for itree_pattern_tx: single frame, backpressure, repeats with gap, abort, reset, start-while-busy.
// Fault-injection vectors run only when ITREE_TX_FAULT_INJECT_EN is defined.
module tb_itree_pattern_tx;
  localparam int PW    = 256;
  localparam int BW    = 8;
  localparam int BEATS = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] pattern_in = '0;
  logic [7:0]    repeat_count = 8'd0;
  logic          busy, done;
  logic [7:0]    byte_index;
`ifdef ITREE_TX_FAULT_INJECT_EN
  logic          inject_en = 1'b0;
  logic [7:0]    inject_idx = 8'd0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] beat_q[$];
  logic [7:0] idx_q[$];
  int         gap_q[$];
  int         done_count, done_cycle, stall_bad, gap_run;
  logic       busy_at_done, busy_after_done;
  logic       snap_valid, snap_busy, snap_done;
  logic [7:0] snap_data, snap_idx;
  logic [7:0] exp_first[BEATS];
  logic [7:0] exp_frame[BEATS];
  logic [PW-1:0] ramp_pat;
  logic [PW-1:0] aa_pat;

  itree_pattern_tx_if #(.BYTE_W(BW)) tx_if ();

  itree_pattern_tx #(.PATTERN_W(PW), .BYTE_W(BW), .GAP_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .pattern_in   (pattern_in),
    .repeat_count (repeat_count),
`ifdef ITREE_TX_FAULT_INJECT_EN
    .inject_en    (inject_en),
    .inject_idx   (inject_idx),
`endif
    .tx           (tx_if),
    .busy         (busy),
    .done         (done),
    .byte_index   (byte_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_exp(input logic [PW-1:0] pat);
    for (int k = 0; k < BEATS; k++) begin
      exp_frame[k] = pat[k*8 +: 8];
      exp_first[k] = pat[k*8 +: 8];
    end
  endtask

  task automatic drive_start(input logic [PW-1:0] pat, input logic [7:0] rc);
    @(negedge clk);
    pattern_in   = pat;
    repeat_count = rc;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle c=1 is the cycle after start was accepted; sampling is at the falling edge.
  task automatic collect(input int budget, input int rmode, input int abort_c,
                         input int start_c, input int rst_c);
    logic pv, pr;
    logic [7:0] pd, pi;
    int ev;
    beat_q.delete(); idx_q.delete(); gap_q.delete();
    done_count = 0; done_cycle = -1; stall_bad = 0; gap_run = 0;
    busy_at_done = 1'b1; busy_after_done = 1'b1;
    snap_valid = 1'bx; snap_busy = 1'bx; snap_done = 1'bx; snap_data = 'x; snap_idx = 'x;
    ev = (abort_c > 0) ? abort_c : rst_c;
    pv = 1'b0; pr = 1'b0; pd = '0; pi = '0;
    for (int c = 1; c <= budget; c++) begin
      tx_if.data_ready = (rmode == 0) ? 1'b1 : (((c - 1) % 3) == 0);
      abort = (c == abort_c);
      start = (c == start_c);
      reset = (c == rst_c);
      @(negedge clk);
      if (pv && !pr && (!tx_if.data_valid || tx_if.data_out !== pd || byte_index !== pi))
        stall_bad++;
      if (tx_if.data_valid && tx_if.data_ready) begin
        beat_q.push_back(tx_if.data_out);
        idx_q.push_back(byte_index);
      end
      if (!tx_if.data_valid && busy) gap_run++;
      else if (tx_if.data_valid && gap_run > 0) begin
        gap_q.push_back(gap_run);
        gap_run = 0;
      end
      if (ev > 0 && c == ev + 1) begin
        snap_valid = tx_if.data_valid; snap_busy = busy; snap_done = done;
        snap_data  = tx_if.data_out;   snap_idx  = byte_index;
      end
      if (done_cycle > 0 && c == done_cycle + 1) begin
        busy_after_done = busy;
        break;
      end
      if (done) begin
        done_count++;
        done_cycle   = c;
        busy_at_done = busy;
      end
      if (ev > 0 && c == ev + 3) break;
      pv = tx_if.data_valid; pr = tx_if.data_ready; pd = tx_if.data_out; pi = byte_index;
      @(posedge clk);
      #1;
    end
    abort = 1'b0; start = 1'b0; reset = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int exp_count);
    int bad;
    logic [7:0] e;
    check({tag, "_count"}, beat_q.size(), exp_count);
    bad = 0;
    for (int i = 0; i < beat_q.size(); i++) begin
      e = (i < BEATS) ? exp_first[i % BEATS] : exp_frame[i % BEATS];
      if (beat_q[i] !== e || idx_q[i] !== 8'(i % BEATS)) bad++;
    end
    check({tag, "_beats"}, bad, 0);
  endtask

  initial begin
    for (int k = 0; k < BEATS; k++) begin
      ramp_pat[k*8 +: 8] = 8'(k);
      aa_pat[k*8 +: 8]   = 8'hAA;
    end
    tx_if.data_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", tx_if.data_valid, 0);
    check("rst_data",  tx_if.data_out, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_idx",   byte_index, 0);
    reset = 1'b0;

    // Single frame of 0xAA, sink always ready
    set_exp(aa_pat);
    drive_start(aa_pat, 8'd1);
    collect(60, 0, 0, 0, 0);
    check_stream("single", 32);
    check("single_done_n",     done_count, 1);
    check("single_done_cyc",   done_cycle, 33);
    check("single_busy_done",  busy_at_done, 0);
    check("single_busy_after", busy_after_done, 0);
    check("single_no_gap",     gap_q.size(), 0);

    // Backpressure 1,0,0 repeating: beat k transfers on cycle 3k+1
    set_exp(ramp_pat);
    drive_start(ramp_pat, 8'd1);
    collect(150, 1, 0, 0, 0);
    check_stream("bp", 32);
    check("bp_stable",   stall_bad, 0);
    check("bp_done_n",   done_count, 1);
    check("bp_done_cyc", done_cycle, 95);

    // Three frames with two-cycle gaps
    drive_start(ramp_pat, 8'd3);
    collect(150, 0, 0, 0, 0);
    check_stream("rep", 96);
    check("rep_gap_n",    gap_q.size(), 2);
    check("rep_gap0",     (gap_q.size() > 0) ? gap_q[0] : -1, 2);
    check("rep_gap1",     (gap_q.size() > 1) ? gap_q[1] : -1, 2);
    check("rep_done_n",   done_count, 1);
    check("rep_done_cyc", done_cycle, 101);

    // repeat_count 0 behaves as 1
    set_exp(aa_pat);
    drive_start(aa_pat, 8'd0);
    collect(60, 0, 0, 0, 0);
    check_stream("rc0", 32);
    check("rc0_done_cyc", done_cycle, 33);

    // Abort at beat 10 of frame 2 (cycle 32+2+11 = 45)
    set_exp(ramp_pat);
    drive_start(ramp_pat, 8'd3);
    collect(80, 0, 45, 0, 0);
    check_stream("abort", 43);
    check("abort_valid", snap_valid, 0);
    check("abort_busy",  snap_busy, 0);
    check("abort_done",  done_count, 0);

    // Restart after abort begins at byte_index 0
    drive_start(ramp_pat, 8'd1);
    collect(60, 0, 0, 0, 0);
    check_stream("restart", 32);
    check("restart_done_n", done_count, 1);

    // abort together with start in IDLE: nothing starts
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("idle_abort_busy",  busy, 0);
    check("idle_abort_valid", tx_if.data_valid, 0);

    // start during beat 5 is ignored, new pattern_in is not latched
    set_exp(aa_pat);
    drive_start(aa_pat, 8'd1);
    pattern_in = ramp_pat;
    collect(60, 0, 0, 6, 0);
    check_stream("sbusy", 32);
    check("sbusy_done_n",   done_count, 1);
    check("sbusy_done_cyc", done_cycle, 33);
    repeat (3) @(negedge clk);
    check("sbusy_idle", busy, 0);

    // Reset mid-frame: outputs all zero the next cycle, no done
    drive_start(ramp_pat, 8'd2);
    collect(20, 0, 0, 0, 5);
    check("mrst_valid", snap_valid, 0);
    check("mrst_busy",  snap_busy, 0);
    check("mrst_done",  snap_done, 0);
    check("mrst_data",  snap_data, 0);
    check("mrst_idx",   snap_idx, 0);
    check("mrst_done_n", done_count, 0);

`ifdef ITREE_TX_FAULT_INJECT_EN
    // Bit 9 lands in byte 1 bit 1 of the first frame only
    set_exp('0);
    exp_first[1] = 8'h02;
    inject_en  = 1'b1;
    inject_idx = 8'd9;
    drive_start('0, 8'd2);
    collect(100, 0, 0, 0, 0);
    check_stream("inj", 64);
    check("inj_done_n", done_count, 1);

    // Injection disabled: nothing flipped
    set_exp('0);
    inject_en = 1'b0;
    drive_start('0, 8'd1);
    collect(60, 0, 0, 0, 0);
    check_stream("inj_off", 32);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
